// File: rtl/rf_arb_pkg.sv
// Shared types for the register-file write arbiter: write-request record,
// grant encoding and bus widths.
package rf_arb_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int DATA_W     = 32;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] addr;
      logic [DATA_W-1:0]     data;
      logic [DATA_W-1:0]     pc;
   } wr_req_t;

   localparam int WR_REQ_W = $bits(wr_req_t);

   typedef enum logic [1:0] {
      GNT_NONE,
      GNT_P0,
      GNT_P1,
      GNT_FORCE
   } gnt_t;

   // Both the normal and the forced port-1 grant take the FIFO head.
   function automatic logic gnt_takes_head(input gnt_t gnt);
      return (gnt == GNT_P1) || (gnt == GNT_FORCE);
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// Port-1 writeback buffer. Power-of-two depth; pointers carry one extra bit
// so full and empty are told apart without a separate count register.
module wb_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 69
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             empty,
   output logic             full
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   // Storage is don't-care until written; only the pointers need reset.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr[AW-1:0]] <= push_data;
      end
   end

   assign head = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/rf_wr_arbiter.sv
// Two-port register-file write arbiter: pipeline writeback (port 0) has
// priority, MDU results (port 1) are buffered and forced through after MAX_WAIT losses.
module rf_wr_arbiter
   import rf_arb_pkg::*;
#(
   parameter int FIFO_DEPTH = 2,
   parameter int MAX_WAIT   = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  valid0,
   output logic                  ready0,
   input  logic [REG_ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0]     data0,
   input  logic [DATA_W-1:0]     pc0,
   input  logic                  valid1,
   output logic                  ready1,
   input  logic [REG_ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0]     data1,
   input  logic [DATA_W-1:0]     pc1,
   output logic                  rf_en,
   output logic [REG_ADDR_W-1:0] rf_a3,
   output logic [DATA_W-1:0]     rf_wd,
   output logic [DATA_W-1:0]     rf_wpc,
   output logic                  p1_pending
);

   localparam int WW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
   localparam logic [WW-1:0] WAIT_SAT = WW'(MAX_WAIT);

   wr_req_t               p0_req;
   wr_req_t               p1_req;
   wr_req_t               head_req;
   wr_req_t               sel_req;
   logic [WR_REQ_W-1:0]   head_bits;
   logic                  fifo_empty;
   logic                  fifo_full;
   logic                  push;
   logic                  pop;
   gnt_t                  gnt;
   logic [WW-1:0]         wait_cnt;

   assign p0_req = '{addr: addr0, data: data0, pc: pc0};
   assign p1_req = '{addr: addr1, data: data1, pc: pc1};

   assign ready1     = !fifo_full;
   assign push       = valid1 && ready1;
   assign p1_pending = !fifo_empty;

   wb_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (WR_REQ_W)
   ) u_wb_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (p1_req),
      .pop       (pop),
      .head      (head_bits),
      .empty     (fifo_empty),
      .full      (fifo_full)
   );

   assign head_req = wr_req_t'(head_bits);

   always_comb begin
      gnt = GNT_NONE;
      if (!fifo_empty && (wait_cnt == WAIT_SAT)) begin
         gnt = GNT_FORCE;
      end else if (valid0) begin
         gnt = GNT_P0;
      end else if (!fifo_empty) begin
         gnt = GNT_P1;
      end
   end

   assign ready0 = (gnt != GNT_FORCE);
   assign pop    = gnt_takes_head(gnt);

   always_comb begin
      sel_req = p0_req;
      if (pop) begin
         sel_req = head_req;
      end
   end

   // Ageing of the FIFO head: counts only cycles where it is present and loses.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wait_cnt <= '0;
      end else if (fifo_empty || pop) begin
         wait_cnt <= '0;
      end else if (wait_cnt != WAIT_SAT) begin
         wait_cnt <= wait_cnt + 1'b1;
      end
   end

   // A granted write to $0 is consumed but never reaches the register file.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rf_en  <= 1'b0;
         rf_a3  <= '0;
         rf_wd  <= '0;
         rf_wpc <= '0;
      end else begin
         rf_en <= (gnt != GNT_NONE) && (sel_req.addr != '0);
         if ((gnt != GNT_NONE) && (sel_req.addr != '0)) begin
            rf_a3  <= sel_req.addr;
            rf_wd  <= sel_req.data;
            rf_wpc <= sel_req.pc;
         end
      end
   end

endmodule
